if_id_pipe_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage register with valid/ready handshake, 2-entry skid

---
 rtl/if_id_pipe_stage.sv | 123 ++++++++++++
 tb/tb_if_id_pipe_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid,
// flush to empty, NOP bubble on idle and a saturating stall counter.
module if_id_pipe_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  localparam ent_t C_BUBBLE = '{pc: '0, instr: NOP_INSTR};

  state_t           r_state;
  state_t           w_state_nxt;
  ent_t             r_main;
  ent_t             r_skid;
  ent_t             w_main_nxt;
  ent_t             w_skid_nxt;
  ent_t             w_in_ent;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall;

  // Ready depends on state only, never on out_ready.
  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign out_pc     = r_main.pc;
  assign out_instr  = r_main.instr;
  assign stall_cnt  = r_stall_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;
  assign w_in_ent   = '{pc: in_pc, instr: in_instr};

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = C_BUBBLE;
      w_skid_nxt  = C_BUBBLE;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = w_in_ent;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = w_in_ent;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = w_in_ent;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = C_BUBBLE;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = C_BUBBLE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = C_BUBBLE;
          w_skid_nxt  = C_BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_main  <= C_BUBBLE;
      r_skid  <= C_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: vector table plus FIFO scoreboard,
// flush, async reset and counter saturation sequences.
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_pc;
  logic [31:0] s_out_instr;
  logic [3:0]  s_stall_cnt;

  if_id_pipe_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .stall_cnt (stall_cnt)
  );

  if_id_pipe_stage #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_pc    (s_out_pc),
    .out_instr (s_out_instr),
    .stall_cnt (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    logic        exp_ov;
    logic        exp_ir;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  int          n_vec;
  int          n_err;
  int          m_cnt;
  int          m_cnt4;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the negedge, check outputs, then model the edge.
  task automatic cycle(input vec_t v, input string tag);
    logic ifire;
    logic ofire;
    in_valid  = v.iv;
    in_pc     = v.pc;
    in_instr  = v.ins;
    out_ready = v.ordy;
    flush     = v.fl;
    #1;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.exp_ov});
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.exp_ir});
    if (v.exp_ov && sb.size() > 0) begin
      chk({tag, " out_pc"}, out_pc, sb[0].pc);
      chk({tag, " out_instr"}, out_instr, sb[0].ins);
    end else begin
      chk({tag, " bubble pc"}, out_pc, 32'd0);
      chk({tag, " bubble instr"}, out_instr, NOP);
    end
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, m_cnt);
    chk({tag, " stall_cnt4"}, {28'd0, s_stall_cnt}, m_cnt4);
    ifire = v.iv && (sb.size() < 2);
    ofire = (sb.size() > 0) && v.ordy;
    if (sb.size() > 0 && !v.ordy) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (v.fl) begin
      sb.delete();
    end else begin
      if (ofire) void'(sb.pop_front());
      if (ifire) sb.push_back('{pc: v.pc, ins: v.ins});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] pc,
                              input logic [31:0] ins, input logic ordy,
                              input logic fl, input logic ov,
                              input logic ir);
    vec_t v;
    v = '{iv: iv, pc: pc, ins: ins, ordy: ordy, fl: fl,
          exp_ov: ov, exp_ir: ir};
    return v;
  endfunction

  initial begin
    n_vec     = 0;
    n_err     = 0;
    m_cnt     = 0;
    m_cnt4    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // reset, stream, backpressure, flush in FULL/ONE/with out fire
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h00, 32'hA0A0_0001, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h04, 32'hB0B0_0002, 1, 0, 1, 1));
    tbl.push_back(mk(1, 32'h08, 32'hC0C0_0003, 1, 0, 1, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 1, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h10, 32'hD0D0_0004, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h14, 32'hE0E0_0005, 0, 0, 1, 1));
    tbl.push_back(mk(1, 32'h18, 32'hDEAD_BEEF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h00, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 1, 0));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 1, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h30, 32'h1111_0006, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h34, 32'h2222_0007, 0, 0, 1, 1));
    tbl.push_back(mk(1, 32'h20, 32'hF0F0_0008, 0, 1, 1, 0));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h40, 32'h3333_0009, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h44, 32'h4444_000A, 0, 1, 1, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h50, 32'h5555_000B, 1, 0, 0, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 1, 1, 1));
    tbl.push_back(mk(0, 32'h00, 32'h0,        1, 0, 0, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i], $sformatf("v%0d", i));
    end

    // async reset while FULL, asserted between clock edges
    cycle(mk(1, 32'h60, 32'h6666_000C, 0, 0, 0, 1), "ar0");
    cycle(mk(1, 32'h64, 32'h7777_000D, 0, 0, 1, 1), "ar1");
    chk("ar full in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar out_pc", out_pc, 32'd0);
    chk("ar out_instr", out_instr, NOP);
    chk("ar stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("ar in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    m_cnt  = 0;
    m_cnt4 = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // counter saturation: one held entry, 20 stall cycles
    cycle(mk(1, 32'h70, 32'h8888_000E, 0, 0, 0, 1), "sat0");
    for (int i = 0; i < 20; i++) begin
      cycle(mk(0, 32'h00, 32'h0, 0, 0, 1, 1), $sformatf("sat%0d", i + 1));
    end
    #1;
    chk("sat cnt4", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat cnt16", {16'd0, stall_cnt}, 32'd20);
    cycle(mk(0, 32'h00, 32'h0, 0, 1, 1, 1), "satfl");
    #1;
    chk("flush keeps cnt4", {28'd0, s_stall_cnt}, 32'd15);
    chk("flush keeps cnt16", {16'd0, stall_cnt}, 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
